// File: rtl/uart_pkg.sv
// Shared UART types and line levels for the TX path (and the future uart_rx).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_sync_fifo.sv
// Registered synchronous FIFO with full/empty/level; head word visible on data_o.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
  assign rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign data_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised FIFO-fed UART transmitter; frames are sent back-to-back.
// Optional parity bit compiled in with UART_TX_PARITY_EN.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 521,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          tx_ready,
  input  logic                          parity_odd,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = 4;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                tick;
  logic                load;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_rdata;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid),
    .data_i  (tx_data),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: load = ~fifo_empty;
      START: begin
        if (tick) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == BW'(DATA_W - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = PARITY;
`else
            txd_d   = UART_IDLE_LVL;
            state_d = STOP;
`endif
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          txd_d   = UART_IDLE_LVL;
          bit_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            load = ~fifo_empty;
            if (fifo_empty) state_d = IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = UART_IDLE_LVL;
      end
    endcase

    // Shared pop path: from IDLE and from the last stop tick straight into START.
    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_rdata;
      txd_d   = UART_START_LVL;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_rdata ^ parity_odd;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign txd      = txd_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_ready = ~fifo_full;

endmodule
